// File: rtl/riscv_core_amo_unit.sv
`default_nettype none
// ============================================================================
// Module  : riscv_core_amo_unit
// Purpose : RV64A atomic engine. It runs the AMO read-modify-write sequence and
//           LR/SC with a single-entry reservation.
// Rev     : 1.0  initial release
// ============================================================================
module riscv_core_amo_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_amo_valid,
  output logic                  o_amo_ready,
  input  logic [3:0]            i_amo_op,
  input  logic                  i_amo_word,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data_from_core,
  output logic                  o_amo_done,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_amo_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic                  o_mem_word,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_resv_clear
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] OP_SWAP = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MAX  = 4'd5;
  localparam logic [3:0] OP_MIN  = 4'd6;
  localparam logic [3:0] OP_MAXU = 4'd7;
  localparam logic [3:0] OP_MINU = 4'd8;
  localparam logic [3:0] OP_LR   = 4'd9;
  localparam logic [3:0] OP_SC   = 4'd10;

  localparam int HI_W = DATA_WIDTH - 32;
  localparam logic [DATA_WIDTH-1:0] C_ONE = DATA_WIDTH'(1);

  logic [1:0]            r_state;
  logic [3:0]            r_op;
  logic                  r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_core;
  logic [DATA_WIDTH-1:0] r_old;
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  r_err;
  logic                  r_resv_valid;
  logic [ADDR_WIDTH-1:0] r_resv_addr;

  logic                  w_accept;
  logic                  w_sc_hit;
  logic                  w_lr_done;
  logic [DATA_WIDTH-1:0] w_mem_s;
  logic [DATA_WIDTH-1:0] w_mem_u;
  logic [DATA_WIDTH-1:0] w_core_s;
  logic [DATA_WIDTH-1:0] w_core_u;
  logic                  w_gt_s;
  logic                  w_lt_s;
  logic                  w_gt_u;
  logic                  w_lt_u;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata_ext;

  assign w_accept  = i_amo_valid && (r_state == S_IDLE);
  // A clear arriving with the SC itself wins, so the SC must fail.
  assign w_sc_hit  = r_resv_valid && (r_resv_addr == i_addr) && !i_resv_clear;
  assign w_lr_done = (r_state == S_READ) && i_mem_ack && (r_op == OP_LR);

  // Word ops: signed view sign-extends, unsigned view zero-extends bit 31,
  // so full-width compares give the 32-bit result.
  assign w_mem_s  = r_word ? {{HI_W{r_old[31]}}, r_old[31:0]}   : r_old;
  assign w_mem_u  = r_word ? {{HI_W{1'b0}}, r_old[31:0]}        : r_old;
  assign w_core_s = r_word ? {{HI_W{r_core[31]}}, r_core[31:0]} : r_core;
  assign w_core_u = r_word ? {{HI_W{1'b0}}, r_core[31:0]}       : r_core;

  assign w_gt_s = $signed(w_mem_s) > $signed(w_core_s);
  assign w_lt_s = $signed(w_mem_s) < $signed(w_core_s);
  assign w_gt_u = w_mem_u > w_core_u;
  assign w_lt_u = w_mem_u < w_core_u;

  always_comb begin
    w_alu = w_core_u;
    case (r_op)
      OP_SWAP: w_alu = w_core_u;
      OP_ADD:  w_alu = w_mem_u + w_core_u;
      OP_AND:  w_alu = w_mem_u & w_core_u;
      OP_OR:   w_alu = w_mem_u | w_core_u;
      OP_XOR:  w_alu = w_mem_u ^ w_core_u;
      OP_MAX:  w_alu = w_gt_s ? w_mem_u : w_core_u;
      OP_MIN:  w_alu = w_lt_s ? w_mem_u : w_core_u;
      OP_MAXU: w_alu = w_gt_u ? w_mem_u : w_core_u;
      OP_MINU: w_alu = w_lt_u ? w_mem_u : w_core_u;
      default: w_alu = w_core_u;
    endcase
  end

  assign w_wdata     = r_word ? {{HI_W{1'b0}}, w_alu[31:0]} : w_alu;
  assign w_rdata_ext = r_word ? {{HI_W{i_mem_rdata[31]}}, i_mem_rdata[31:0]} : i_mem_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_word  <= 1'b0;
      r_addr  <= '0;
      r_core  <= '0;
      r_old   <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_amo_valid) begin
            r_op   <= i_amo_op;
            r_word <= i_amo_word;
            r_addr <= i_addr;
            r_core <= i_data_from_core;
            r_err  <= 1'b0;
            if (i_amo_op <= OP_LR) begin
              r_state <= S_READ;
            end else if (i_amo_op == OP_SC) begin
              if (w_sc_hit) begin
                r_state <= S_WRITE;
              end else begin
                r_rd    <= C_ONE;
                r_state <= S_RESP;
              end
            end else begin
              r_err   <= 1'b1;
              r_rd    <= '0;
              r_state <= S_RESP;
            end
          end
        end
        S_READ: begin
          if (i_mem_ack) begin
            r_old   <= i_mem_rdata;
            r_rd    <= w_rdata_ext;
            r_state <= (r_op == OP_LR) ? S_RESP : S_WRITE;
          end
        end
        S_WRITE: begin
          if (i_mem_ack) begin
            if (r_op == OP_SC) r_rd <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resv_valid <= 1'b0;
      r_resv_addr  <= '0;
    end else if (i_resv_clear) begin
      r_resv_valid <= 1'b0;
    end else if (w_lr_done) begin
      r_resv_valid <= 1'b1;
      r_resv_addr  <= r_addr;
    end else if (w_accept && (i_amo_op == OP_SC)) begin
      r_resv_valid <= 1'b0;
    end
  end

  assign o_amo_ready = (r_state == S_IDLE);
  assign o_amo_done  = (r_state == S_RESP);
  assign o_amo_err   = (r_state == S_RESP) && r_err;
  assign o_rd_data   = r_rd;
  assign o_mem_req   = (r_state == S_READ) || (r_state == S_WRITE);
  assign o_mem_we    = (r_state == S_WRITE);
  assign o_mem_word  = r_word;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = (r_state != S_WRITE) ? '0 :
                       (r_op == OP_SC)      ? w_core_u : w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_amo_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_riscv_core_amo_unit
// Purpose : Directed and random checks of riscv_core_amo_unit against a
//           memory/reservation reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_riscv_core_amo_unit;

  localparam logic [3:0] OP_SWAP = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_MAX  = 4'd5;
  localparam logic [3:0] OP_MAXU = 4'd7;
  localparam logic [3:0] OP_LR   = 4'd9;
  localparam logic [3:0] OP_SC   = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        amo_valid = 1'b0;
  logic        amo_ready;
  logic [3:0]  amo_op = '0;
  logic        amo_word = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] core_data = '0;
  logic        amo_done;
  logic [63:0] rd_data;
  logic        amo_err;
  logic        mem_req;
  logic        mem_we;
  logic        mem_word;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        resv_clear = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem [logic [63:0]];
  bit          m_rv = 1'b0;
  logic [63:0] m_ra = '0;

  riscv_core_amo_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) u_dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_amo_valid      (amo_valid),
    .o_amo_ready      (amo_ready),
    .i_amo_op         (amo_op),
    .i_amo_word       (amo_word),
    .i_addr           (addr),
    .i_data_from_core (core_data),
    .o_amo_done       (amo_done),
    .o_rd_data        (rd_data),
    .o_amo_err        (amo_err),
    .o_mem_req        (mem_req),
    .o_mem_we         (mem_we),
    .o_mem_word       (mem_word),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .i_mem_ack        (mem_ack),
    .i_mem_rdata      (mem_rdata),
    .i_resv_clear     (resv_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_peek(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  // Reference result of an AMO from memory value m and core value c.
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input bit w,
                                          input logic [63:0] m, input logic [63:0] c);
    int                ms, cs;
    int unsigned       mu, cu, r32;
    longint            dms, dcs;
    longint unsigned   dmu, dcu, r64;
    ms = m[31:0]; cs = c[31:0]; mu = m[31:0]; cu = c[31:0];
    dms = m; dcs = c; dmu = m; dcu = c;
    if (w) begin
      case (op)
        4'd1:    r32 = mu + cu;
        4'd2:    r32 = mu & cu;
        4'd3:    r32 = mu | cu;
        4'd4:    r32 = mu ^ cu;
        4'd5:    r32 = (ms > cs) ? mu : cu;
        4'd6:    r32 = (ms < cs) ? mu : cu;
        4'd7:    r32 = (mu > cu) ? mu : cu;
        4'd8:    r32 = (mu < cu) ? mu : cu;
        default: r32 = cu;
      endcase
      return {32'h0, r32};
    end
    case (op)
      4'd1:    r64 = dmu + dcu;
      4'd2:    r64 = dmu & dcu;
      4'd3:    r64 = dmu | dcu;
      4'd4:    r64 = dmu ^ dcu;
      4'd5:    r64 = (dms > dcs) ? dmu : dcu;
      4'd6:    r64 = (dms < dcs) ? dmu : dcu;
      4'd7:    r64 = (dmu > dcu) ? dmu : dcu;
      4'd8:    r64 = (dmu < dcu) ? dmu : dcu;
      default: r64 = dcu;
    endcase
    return r64;
  endfunction

  // One complete operation; clr_cyc pulses i_resv_clear in that cycle (accept = 1).
  task automatic do_op(input logic [3:0] op, input bit w, input logic [63:0] a,
                       input logic [63:0] c, input int waits, input int clr_cyc,
                       output logic [63:0] o_rd, output logic [63:0] o_wd, output int o_lat);
    bit          legal, is_lr, is_sc, sc_ok, exp_r, exp_w, seen_done, err_seen, clr_eff;
    logic [63:0] old, exp_wd, exp_rd;
    int          exp_lat, nrd, nwr, cyc, wcnt;
    legal  = (op <= 4'd10);
    is_lr  = (op == OP_LR);
    is_sc  = (op == OP_SC);
    sc_ok  = is_sc && m_rv && (m_ra == a) && (clr_cyc != 1);
    exp_r  = legal && !is_sc;
    exp_w  = (legal && op <= 4'd8) || sc_ok;
    old    = exp_r ? mem_peek(a) : 64'h0;
    exp_wd = is_sc ? (w ? {32'h0, c[31:0]} : c) : ref_alu(op, w, old, c);
    if (!legal)     exp_rd = 64'h0;
    else if (is_sc) exp_rd = sc_ok ? 64'h0 : 64'h1;
    else            exp_rd = w ? {{32{old[31]}}, old[31:0]} : old;
    exp_lat = 2 + (exp_r ? waits + 1 : 0) + (exp_w ? waits + 1 : 0);
    clr_eff = (clr_cyc != 0) && (clr_cyc <= exp_lat);

    @(negedge clk);
    check_eq("ready_idle", amo_ready, 1);
    amo_valid = 1'b1; amo_op = op; amo_word = w; addr = a; core_data = c;
    resv_clear = (clr_cyc == 1);
    @(posedge clk); #1;
    amo_valid = 1'b0; amo_op = 4'($urandom); addr = {$urandom, $urandom};
    core_data = {$urandom, $urandom}; resv_clear = 1'b0;
    cyc = 1; nrd = 0; nwr = 0; wcnt = 0; seen_done = 0; err_seen = 0;
    o_rd = '0; o_wd = '0; o_lat = 0;
    while (!seen_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      resv_clear = (cyc == clr_cyc);
      if (amo_done) begin
        seen_done = 1; o_rd = rd_data; err_seen = amo_err; o_lat = cyc;
      end
      if (mem_req) begin
        check_eq("mem_addr", mem_addr, a);
        check_eq("mem_word", mem_word, w);
        if (wcnt == waits) begin
          mem_ack = 1'b1; wcnt = 0;
          if (mem_we) begin nwr++; o_wd = mem_wdata; end
          else begin nrd++; mem_rdata = mem_peek(a); end
        end else begin
          wcnt++;
          mem_rdata = {$urandom, $urandom};
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; resv_clear = 1'b0;
    end
    check_eq("done_seen", seen_done, 1);
    check_eq("rd", o_rd, exp_rd);
    check_eq("err", err_seen, !legal);
    check_eq("latency", o_lat, exp_lat);
    check_eq("n_reads", nrd, exp_r);
    check_eq("n_writes", nwr, exp_w);
    if (exp_w) check_eq("wdata", o_wd, exp_wd);

    if (exp_w) begin
      if (w) mem[a] = {mem_peek(a) >> 32, exp_wd[31:0]};
      else   mem[a] = exp_wd;
    end
    if (is_sc)        m_rv = 1'b0;
    else if (is_lr) begin
      m_rv = !(clr_eff && clr_cyc >= 2 + waits);
      m_ra = a;
    end else if (clr_eff) m_rv = 1'b0;
  endtask

  function automatic logic [63:0] pick_val(input logic [63:0] a);
    case ($urandom_range(0, 6))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h0000_0000_8000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return mem_peek(a);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [63:0] rd, wd;
  int          lat;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", amo_ready, 1);
    check_eq("rst_done", amo_done, 0);
    check_eq("rst_rd", rd_data, 0);
    check_eq("rst_err", amo_err, 0);
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_word", mem_word, 0);
    rst_n = 1'b1;

    mem[64'h10] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_op(OP_ADD, 0, 64'h10, 64'h1, 0, 0, rd, wd, lat);
    check_eq("add_d_wdata", wd, 64'h0);
    check_eq("add_d_rd", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("add_d_lat", lat, 4);

    mem[64'h20] = 64'h0000_0000_8000_0000;
    do_op(OP_MAX, 1, 64'h20, 64'h1, 0, 0, rd, wd, lat);
    check_eq("max_w_wdata", wd, 64'h1);
    check_eq("max_w_rd", rd, 64'hFFFF_FFFF_8000_0000);
    mem[64'h20] = 64'h0000_0000_8000_0000;
    do_op(OP_MAXU, 1, 64'h20, 64'h1, 0, 0, rd, wd, lat);
    check_eq("maxu_w_wdata", wd, 64'h8000_0000);

    do_op(OP_LR, 0, 64'h1000, 64'h0, 0, 0, rd, wd, lat);
    check_eq("lr_lat", lat, 3);
    do_op(OP_SC, 0, 64'h1000, 64'h55, 0, 0, rd, wd, lat);
    check_eq("sc_ok_wdata", wd, 64'h55);
    check_eq("sc_ok_rd", rd, 64'h0);
    check_eq("sc_ok_lat", lat, 3);
    do_op(OP_SC, 0, 64'h1000, 64'h66, 0, 0, rd, wd, lat);
    check_eq("sc_again_rd", rd, 64'h1);
    check_eq("sc_again_lat", lat, 2);

    do_op(OP_LR, 1, 64'h2000, 64'h0, 0, 0, rd, wd, lat);
    @(negedge clk); resv_clear = 1'b1;
    @(negedge clk); resv_clear = 1'b0;
    m_rv = 1'b0;
    do_op(OP_SC, 1, 64'h2000, 64'h77, 0, 0, rd, wd, lat);
    check_eq("sc_after_clr_rd", rd, 64'h1);
    do_op(OP_LR, 1, 64'h2000, 64'h0, 0, 0, rd, wd, lat);
    do_op(OP_SC, 1, 64'h2008, 64'h77, 0, 0, rd, wd, lat);
    check_eq("sc_wrong_addr_rd", rd, 64'h1);
    do_op(OP_LR, 0, 64'h2000, 64'h0, 0, 0, rd, wd, lat);
    do_op(OP_SC, 0, 64'h2000, 64'h77, 0, 1, rd, wd, lat);
    check_eq("sc_clr_at_accept_rd", rd, 64'h1);
    do_op(OP_LR, 0, 64'h2000, 64'h0, 1, 3, rd, wd, lat);
    do_op(OP_SC, 0, 64'h2000, 64'h77, 0, 0, rd, wd, lat);
    check_eq("sc_clr_at_lr_ack_rd", rd, 64'h1);

    do_op(4'd12, 0, 64'h40, 64'h9, 0, 0, rd, wd, lat);
    check_eq("illegal_lat", lat, 2);
    check_eq("illegal_rd", rd, 64'h0);

    do_op(OP_SWAP, 0, 64'h48, 64'hDEAD_BEEF_0123_4567, 3, 0, rd, wd, lat);
    check_eq("swap_wait_lat", lat, 10);

    // Abort an AMO in its write phase; the reservation must not survive.
    do_op(OP_LR, 0, 64'h3000, 64'h0, 0, 0, rd, wd, lat);
    @(negedge clk);
    amo_valid = 1'b1; amo_op = OP_ADD; amo_word = 1'b0; addr = 64'h3000; core_data = 64'h5;
    @(posedge clk); #1;
    amo_valid = 1'b0;
    begin
      bit in_write;
      in_write = 0;
      for (int i = 0; i < 20 && !in_write; i++) begin
        @(negedge clk);
        if (mem_req && mem_we) in_write = 1;
        else begin
          if (mem_req) begin mem_ack = 1'b1; mem_rdata = mem_peek(64'h3000); end
          @(posedge clk); #1;
          mem_ack = 1'b0;
        end
      end
      check_eq("rst_reached_write", in_write, 1);
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_req", mem_req, 0);
    check_eq("abort_ready", amo_ready, 1);
    check_eq("abort_done", amo_done, 0);
    check_eq("abort_rd", rd_data, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_rv = 1'b0;
    do_op(OP_SC, 0, 64'h3000, 64'h99, 0, 0, rd, wd, lat);
    check_eq("sc_after_reset_rd", rd, 64'h1);

    for (int n = 0; n < 80; n++) begin
      logic [3:0]  op;
      logic [63:0] a;
      int          sel, clr;
      sel = $urandom_range(0, 19);
      if (sel <= 8)       op = 4'(sel);
      else if (sel <= 12) op = OP_LR;
      else if (sel <= 17) op = OP_SC;
      else                op = 4'($urandom_range(11, 15));
      case ($urandom_range(0, 2))
        0:       a = 64'h100;
        1:       a = 64'h108;
        default: a = 64'h200;
      endcase
      clr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0;
      do_op(op, 1'($urandom_range(0, 1)), a, pick_val(a), $urandom_range(0, 2), clr,
            rd, wd, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
